// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces the
//   result over whole scans and reports one pressed key as a 4-bit hex code
//   {row_idx, col_idx}, suitable for the hex2seg display bus.
//
// Ports
//   clock      in   system clock, all state on rising edge
//   nReset     in   asynchronous active-low reset
//   enable     in   1 = scan, 0 = freeze scanning (columns released)
//   row_n[3:0] in   keypad rows, active-low, asynchronous to clock
//   col_n[3:0] out  column drive, active-low one-hot
//   key[3:0]   out  last accepted key code
//   key_valid  out  one-cycle pulse on each newly accepted press
//   key_held   out  high from key_valid until the debounced release
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       nReset,
    input  logic       enable,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(DEBOUNCE_SCANS);
    localparam bit               ACCEPT_FIRST = (DEBOUNCE_SCANS == 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } scan_res_e;

    // Row synchronizer
    logic [3:0] row_meta_q, row_meta_d;
    logic [3:0] row_sync_q, row_sync_d;

    // Becomes 1 on the first clock after reset so columns stay released
    // for the whole reset period regardless of enable.
    logic run_q, run_d;

    // Scan sequencing and per-scan accumulation
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       acc_cnt_q, acc_cnt_d;   // intersections seen, saturates at 2
    logic [3:0]       acc_code_q, acc_code_d; // code of the first intersection

    // Debounce FSM and outputs
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic       scan_active;
    logic       scan_end;
    scan_res_e  scan_res;
    logic [3:0] scan_code;
    logic [2:0] col_hits;
    logic [1:0] first_row;
    logic [2:0] total_hits;
    logic [3:0] new_code;

    assign scan_active = enable && run_q;

    assign col_n     = scan_active ? ~(4'b0001 << col_q) : '1;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

    always_comb begin
        row_meta_d = row_n;
        row_sync_d = row_meta_q;
        run_d      = 1'b1;
    end

    // Column sequencing and scan classification.
    // While disabled the divider, column and partial scan are parked at
    // zero rather than held: the next enable restarts from col 0 and drops
    // the partial scan anyway, so the visible behaviour is the same.
    always_comb begin
        div_d      = div_q;
        col_d      = col_q;
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        scan_end   = 1'b0;
        scan_res   = RES_NONE;
        scan_code  = acc_code_q;
        col_hits   = '0;
        first_row  = '0;

        for (int unsigned r = 0; r < 4; r++) begin
            if (!row_sync_q[r]) begin
                if (col_hits == 3'd0) begin
                    first_row = 2'(r);
                end
                col_hits = col_hits + 3'd1;
            end
        end

        total_hits = {1'b0, acc_cnt_q} + col_hits;
        new_code   = (acc_cnt_q == 2'd0) ? {first_row, col_q} : acc_code_q;

        if (!scan_active) begin
            div_d      = '0;
            col_d      = '0;
            acc_cnt_d  = '0;
            acc_code_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) begin
                scan_end  = 1'b1;
                scan_code = new_code;
                if (total_hits == 3'd0) begin
                    scan_res = RES_NONE;
                end else if (total_hits == 3'd1) begin
                    scan_res = RES_SINGLE;
                end else begin
                    scan_res = RES_MULTI;
                end
                acc_cnt_d  = '0;
                acc_code_d = '0;
            end else begin
                acc_cnt_d  = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
                acc_code_d = new_code;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Debounce FSM, evaluated once per completed scan
    always_comb begin
        logic       do_accept;
        logic [3:0] accept_code;
        logic [CNT_W-1:0] cnt_inc;

        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        do_accept   = 1'b0;
        accept_code = cand_q;
        cnt_inc     = cnt_q + CNT_ONE;

        if (scan_end) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (scan_res == RES_SINGLE) begin
                        cand_d = scan_code;
                        if (ACCEPT_FIRST) begin
                            do_accept   = 1'b1;
                            accept_code = scan_code;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (scan_res == RES_SINGLE && scan_code == cand_q) begin
                        if (cnt_inc == CNT_MAX) begin
                            do_accept   = 1'b1;
                            accept_code = cand_q;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (scan_res == RES_NONE) begin
                        if (ACCEPT_FIRST) begin
                            state_d    = ST_IDLE;
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                        end else begin
                            state_d = ST_RELEASE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (scan_res == RES_NONE) begin
                        if (cnt_inc == CNT_MAX) begin
                            state_d    = ST_IDLE;
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (do_accept) begin
                state_d     = ST_PRESSED;
                cnt_d       = '0;
                key_d       = accept_code;
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            row_meta_q  <= '1;
            row_sync_q  <= '1;
            run_q       <= 1'b0;
            div_q       <= '0;
            col_q       <= '0;
            acc_cnt_q   <= '0;
            acc_code_q  <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            run_q       <= run_d;
            div_q       <= div_d;
            col_q       <= col_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle scan).
// A keypad model turns the set of pressed keys into row levels from the
// driven columns. A behavioural model classifies each full scan by the
// number of pressed keys and tracks press/release run lengths.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DS = 2;
    localparam int SCAN_LEN = 4 * SD;

    logic       clock  = 1'b0;
    logic       nReset = 1'b0;
    logic       enable = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    // Bit index r*4+c is the key at row r, column c, whose code is that index.
    logic [15:0] pressed = '0;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // Behavioural model state
    int         m_phase   = 0;
    bit         m_started = 1'b0;
    bit         m_held    = 1'b0;
    bit         m_valid   = 1'b0;
    logic [3:0] m_key     = '0;
    logic [3:0] m_cand    = '0;
    int         m_run     = 0;
    int         m_rel     = 0;

    always #5 clock = ~clock;

    keypad_scanner #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DS)
    ) dut (
        .clock    (clock),
        .nReset   (nReset),
        .enable   (enable),
        .row_n    (row_n),
        .col_n    (col_n),
        .key      (key),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic eval_scan();
        int n;
        logic [3:0] k;
        n = $countones(pressed);
        k = '0;
        for (int i = 0; i < 16; i++) if (pressed[i]) k = 4'(i);
        if (!m_held) begin
            if (m_run == 0) begin
                if (n == 1) begin
                    m_cand = k;
                    m_run  = 1;
                end
            end else if (n == 1 && k == m_cand) begin
                m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run == DS) begin
                m_held  = 1'b1;
                m_valid = 1'b1;
                m_key   = m_cand;
                m_run   = 0;
            end
        end else begin
            if (n == 0) m_rel++;
            else m_rel = 0;
            if (m_rel == DS) begin
                m_held = 1'b0;
                m_rel  = 0;
            end
        end
    endtask

    always @(posedge clock) begin
        if (!nReset) begin
            m_phase = 0; m_started = 1'b0; m_held = 1'b0; m_valid = 1'b0;
            m_key = '0; m_cand = '0; m_run = 0; m_rel = 0;
        end else begin
            m_valid = 1'b0;
            if (m_started && enable) begin
                m_phase++;
                if (m_phase == SCAN_LEN) begin
                    m_phase = 0;
                    eval_scan();
                end
            end else begin
                m_phase = 0;
            end
            m_started = 1'b1;
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clock) begin
        logic [3:0] one;
        logic [3:0] exp_col;
        #1;
        if (nReset) begin
            one     = 4'b0001;
            exp_col = (enable && m_started) ? ~(one << (m_phase / SD)) : 4'hF;
            check("col_n", col_n, exp_col);
            check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
            check("key_held", {3'b0, key_held}, {3'b0, m_held});
            check("key", key, m_key);
            if (key_valid === 1'b1) pulses++;
        end
    end

    // Returns at the first falling edge following a scan end.
    task automatic next_scan();
        int guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (m_phase != 0 && guard < 100);
        if (guard >= 100) check("scan_boundary_timeout", 4'h1, 4'h0);
    endtask

    task automatic scans(input int n);
        repeat (n) next_scan();
    endtask

    initial begin
        int p0;
        int lat;

        // Reset values before any clock is released
        #12;
        check("rst_col_n", col_n, 4'hF);
        check("rst_key", key, 4'h0);
        check("rst_valid", {3'b0, key_valid}, 4'h0);
        check("rst_held", {3'b0, key_held}, 4'h0);
        @(negedge clock) nReset = 1'b1;
        @(posedge clock); #1;
        check("col0_after_reset", col_n, 4'hE);
        repeat (4) @(posedge clock); #1;
        check("col1_after_4", col_n, 4'hD);
        repeat (4) @(posedge clock); #1;
        check("col2_after_8", col_n, 4'hB);

        // Clean press of row2/col1 -> 4'h9
        next_scan();
        p0 = pulses;
        pressed[9] = 1'b1;
        lat = 0;
        while (key_valid !== 1'b1 && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        check("press_latency_cycles", 4'(lat - 16), 4'(32 - 16));
        check("press_key", key, 4'h9);
        check("press_held", {3'b0, key_held}, 4'h1);
        scans(8);
        pressed = '0;
        scans(1);
        check("held_after_1_none", {3'b0, key_held}, 4'h1);
        scans(1);
        check("held_after_2_none", {3'b0, key_held}, 4'h0);
        check("key_kept_after_release", key, 4'h9);
        check("clean_pulse_count", 4'(pulses - p0), 4'h1);

        // Bounce: row0/col3 for one scan only
        p0 = pulses;
        pressed[3] = 1'b1;
        scans(1);
        pressed = '0;
        scans(3);
        check("bounce_pulse_count", 4'(pulses - p0), 4'h0);
        check("bounce_key", key, 4'h9);

        // Ghosting: row0/col0 and row1/col2 together
        p0 = pulses;
        pressed[0] = 1'b1;
        pressed[6] = 1'b1;
        scans(6);
        pressed = '0;
        scans(2);
        check("ghost_pulse_count", 4'(pulses - p0), 4'h0);
        check("ghost_held", {3'b0, key_held}, 4'h0);

        // Enable gap during debounce, key row3/col0 -> 4'hC
        p0 = pulses;
        pressed[12] = 1'b1;
        scans(1);
        repeat (5) @(negedge clock);
        enable = 1'b0;
        repeat (20) @(negedge clock);
        check("gap_col_n", col_n, 4'hF);
        check("gap_pulse_count", 4'(pulses - p0), 4'h0);
        enable = 1'b1;
        #1;
        check("reenable_col0", col_n, 4'hE);
        next_scan();
        check("reenable_valid", {3'b0, key_valid}, 4'h1);
        check("reenable_key", key, 4'hC);
        check("reenable_pulse_count", 4'(pulses - p0), 4'h1);
        pressed = '0;
        scans(3);

        // Rollover: hold 5, add A, release 5, then release all
        p0 = pulses;
        pressed[5] = 1'b1;
        scans(2);
        check("roll_key", key, 4'h5);
        pressed[10] = 1'b1;
        scans(3);
        pressed[5] = 1'b0;
        scans(3);
        check("roll_held", {3'b0, key_held}, 4'h1);
        check("roll_key_kept", key, 4'h5);
        check("roll_pulse_count", 4'(pulses - p0), 4'h1);
        pressed = '0;
        scans(1);
        check("roll_held_1_none", {3'b0, key_held}, 4'h1);
        scans(1);
        check("roll_held_2_none", {3'b0, key_held}, 4'h0);

        // Reset mid-dwell while a key is held
        pressed[5] = 1'b1;
        scans(2);
        check("pre_reset_held", {3'b0, key_held}, 4'h1);
        repeat (2) @(posedge clock);
        #2 nReset = 1'b0;
        #1;
        check("midrst_col_n", col_n, 4'hF);
        check("midrst_key", key, 4'h0);
        check("midrst_valid", {3'b0, key_valid}, 4'h0);
        check("midrst_held", {3'b0, key_held}, 4'h0);
        pressed = '0;
        @(negedge clock);
        @(negedge clock) nReset = 1'b1;
        @(posedge clock); #1;
        check("col0_after_midrst", col_n, 4'hE);
        repeat (4) @(posedge clock); #1;
        check("col1_after_midrst", col_n, 4'hD);
        scans(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
